// File: rtl/cr16_fetch_pkg.sv
// Shared definitions for the CR16 instruction fetch stage.
//   fetch_state_t         : fetch FSM state encoding
//   DEFAULT_ADDRESS_WIDTH : default PC / instruction memory address width
//   DEFAULT_DATA_WIDTH    : default instruction word width
package cr16_fetch_pkg;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_HOLD,
    S_ADVANCE
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// CR16 instruction fetch stage.
// Samples the PC, issues one read to synchronous instruction memory, captures the returned
// word and presents it to decode with a valid/ready handshake. After each accepted
// instruction or taken branch it emits a single-cycle PC enable pulse, together with the
// redirect selects when a branch is being taken.
//
// Ports:
//   I_CLK, I_NRESET                 clock, asynchronous active-low reset
//   I_ENABLE                        run enable; new fetches start only while high
//   I_PC_ADDRESS                    current PC value
//   O_PC_ENABLE                     registered one-cycle PC update pulse
//   O_PC_ADDRESS_SELECT             with the pulse: load O_PC_ADDRESS instead of incrementing
//   O_PC_ADDRESS_SELECT_INCREMENT   with the pulse: load O_PC_ADDRESS + 1
//   O_PC_ADDRESS                    redirect target for the PC
//   I_BRANCH_VALID/TARGET/PLUS_ONE  one-cycle branch request from execute
//   O_MEM_READ, O_MEM_ADDRESS       memory read strobe/address (decoded from state)
//   I_MEM_DATA                      read data, valid one cycle after O_MEM_READ
//   O_INSTR, O_INSTR_ADDRESS        captured instruction and its fetch address
//   O_INSTR_VALID, I_INSTR_READY    decode handshake
module fetch_unit
  import cr16_fetch_pkg::*;
#(
  parameter int unsigned P_ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned P_DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_ENABLE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_PC_ADDRESS,
  output logic                       O_PC_ENABLE,
  output logic                       O_PC_ADDRESS_SELECT,
  output logic                       O_PC_ADDRESS_SELECT_INCREMENT,
  output logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS,
  input  logic                       I_BRANCH_VALID,
  input  logic [P_ADDRESS_WIDTH-1:0] I_BRANCH_TARGET,
  input  logic                       I_BRANCH_PLUS_ONE,
  output logic                       O_MEM_READ,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
  output logic [P_DATA_WIDTH-1:0]    O_INSTR,
  output logic [P_ADDRESS_WIDTH-1:0] O_INSTR_ADDRESS,
  output logic                       O_INSTR_VALID,
  input  logic                       I_INSTR_READY
);

  fetch_state_t               state_q;
  logic [P_ADDRESS_WIDTH-1:0] addr_q;

  // A branch only matters while a fetch is outstanding; in S_IDLE and S_ADVANCE
  // no instruction is owned by this stage, so the request is ignored.
  logic in_flight;
  logic branch_taken;

  always_comb begin
    in_flight    = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_HOLD);
    branch_taken = I_BRANCH_VALID && in_flight;
  end

  // Memory strobe and address are combinational so the read is issued in the
  // same cycle the FSM enters S_READ.
  always_comb begin
    O_MEM_READ    = (state_q == S_READ);
    O_MEM_ADDRESS = O_MEM_READ ? addr_q : '0;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q                       <= S_IDLE;
      addr_q                        <= '0;
      O_PC_ENABLE                   <= 1'b0;
      O_PC_ADDRESS_SELECT           <= 1'b0;
      O_PC_ADDRESS_SELECT_INCREMENT <= 1'b0;
      O_PC_ADDRESS                  <= '0;
      O_INSTR                       <= '0;
      O_INSTR_ADDRESS               <= '0;
      O_INSTR_VALID                 <= 1'b0;
    end else if (branch_taken) begin
      // Branch wins over capture and over a simultaneous accept; either way a
      // single redirect pulse is issued and any fetched data is dropped.
      O_INSTR_VALID                 <= 1'b0;
      O_PC_ADDRESS                  <= I_BRANCH_TARGET;
      O_PC_ADDRESS_SELECT           <= 1'b1;
      O_PC_ADDRESS_SELECT_INCREMENT <= I_BRANCH_PLUS_ONE;
      O_PC_ENABLE                   <= 1'b1;
      state_q                       <= S_ADVANCE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_ENABLE) begin
            addr_q  <= I_PC_ADDRESS;
            state_q <= S_READ;
          end
        end

        S_READ: begin
          state_q <= S_CAPTURE;
        end

        S_CAPTURE: begin
          O_INSTR         <= I_MEM_DATA;
          O_INSTR_ADDRESS <= addr_q;
          O_INSTR_VALID   <= 1'b1;
          state_q         <= S_HOLD;
        end

        S_HOLD: begin
          if (I_INSTR_READY) begin
            O_INSTR_VALID                 <= 1'b0;
            O_PC_ENABLE                   <= 1'b1;
            O_PC_ADDRESS_SELECT           <= 1'b0;
            O_PC_ADDRESS_SELECT_INCREMENT <= 1'b0;
            state_q                       <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          // The PC has already moved on the pulse's rising edge, so I_PC_ADDRESS
          // here is the next fetch address.
          O_PC_ENABLE                   <= 1'b0;
          O_PC_ADDRESS_SELECT           <= 1'b0;
          O_PC_ADDRESS_SELECT_INCREMENT <= 1'b0;
          if (I_ENABLE) begin
            addr_q  <= I_PC_ADDRESS;
            state_q <= S_READ;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC and synchronous memory environment, a
// phase-level reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic including branches, stalls and resets.
module tb_fetch_unit;

  logic        I_CLK = 1'b0;
  logic        I_NRESET = 1'b0;
  logic        I_ENABLE = 1'b0;
  logic [15:0] I_PC_ADDRESS;
  logic        O_PC_ENABLE;
  logic        O_PC_ADDRESS_SELECT;
  logic        O_PC_ADDRESS_SELECT_INCREMENT;
  logic [15:0] O_PC_ADDRESS;
  logic        I_BRANCH_VALID = 1'b0;
  logic [15:0] I_BRANCH_TARGET = 16'h0000;
  logic        I_BRANCH_PLUS_ONE = 1'b0;
  logic        O_MEM_READ;
  logic [15:0] O_MEM_ADDRESS;
  logic [15:0] I_MEM_DATA = 16'h0000;
  logic [15:0] O_INSTR;
  logic [15:0] O_INSTR_ADDRESS;
  logic        O_INSTR_VALID;
  logic        I_INSTR_READY = 1'b0;

  int checks = 0;
  int errors = 0;

  // Program counter environment, advanced by the bench on each PC pulse.
  logic [15:0] pc = 16'h0010;
  assign I_PC_ADDRESS = pc;

  fetch_unit #(
    .P_ADDRESS_WIDTH(16),
    .P_DATA_WIDTH   (16)
  ) dut (
    .I_CLK                        (I_CLK),
    .I_NRESET                     (I_NRESET),
    .I_ENABLE                     (I_ENABLE),
    .I_PC_ADDRESS                 (I_PC_ADDRESS),
    .O_PC_ENABLE                  (O_PC_ENABLE),
    .O_PC_ADDRESS_SELECT          (O_PC_ADDRESS_SELECT),
    .O_PC_ADDRESS_SELECT_INCREMENT(O_PC_ADDRESS_SELECT_INCREMENT),
    .O_PC_ADDRESS                 (O_PC_ADDRESS),
    .I_BRANCH_VALID               (I_BRANCH_VALID),
    .I_BRANCH_TARGET              (I_BRANCH_TARGET),
    .I_BRANCH_PLUS_ONE            (I_BRANCH_PLUS_ONE),
    .O_MEM_READ                   (O_MEM_READ),
    .O_MEM_ADDRESS                (O_MEM_ADDRESS),
    .I_MEM_DATA                   (I_MEM_DATA),
    .O_INSTR                      (O_INSTR),
    .O_INSTR_ADDRESS              (O_INSTR_ADDRESS),
    .O_INSTR_VALID                (O_INSTR_VALID),
    .I_INSTR_READY                (I_INSTR_READY)
  );

  always #5 I_CLK = ~I_CLK;

  // Instruction memory contents as a pure function of address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5C3;
    return (a * 16'h9E37) ^ 16'h3C5A;
  endfunction

  // Synchronous memory: data for a read appears one cycle later, garbage otherwise.
  always @(posedge I_CLK) begin
    if (O_MEM_READ) I_MEM_DATA <= memf(O_MEM_ADDRESS);
    else            I_MEM_DATA <= 16'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  logic any_out;
  assign any_out = |{O_PC_ENABLE, O_PC_ADDRESS_SELECT, O_PC_ADDRESS_SELECT_INCREMENT,
                     O_PC_ADDRESS, O_MEM_READ, O_MEM_ADDRESS, O_INSTR, O_INSTR_ADDRESS,
                     O_INSTR_VALID};

  // Reference model: tracks which phase of a fetch is outstanding from observed
  // handshakes and predicts next-cycle outputs from the fetch/branch/accept rules.
  logic        exp_pulse, exp_sel, exp_inc, exp_valid, exp_read;
  logic [15:0] exp_pc_addr;
  logic        prev_read_ok, prev_pulse;
  logic        m_capture, m_busy, m_honored;

  always @(negedge I_CLK) begin
    if (!I_NRESET) begin
      check("reset_outputs_zero", 32'(any_out), 32'd0);
      exp_pulse = 1'b0; exp_sel = 1'b0; exp_inc = 1'b0; exp_valid = 1'b0; exp_read = 1'b0;
      exp_pc_addr = 16'h0000; prev_read_ok = 1'b0; prev_pulse = 1'b0;
    end else begin
      check("pc_enable",     32'(O_PC_ENABLE), 32'(exp_pulse));
      check("pc_select",     32'(O_PC_ADDRESS_SELECT), 32'(exp_sel));
      check("pc_select_inc", 32'(O_PC_ADDRESS_SELECT_INCREMENT), 32'(exp_inc));
      check("pc_address",    32'(O_PC_ADDRESS), 32'(exp_pc_addr));
      check("instr_valid",   32'(O_INSTR_VALID), 32'(exp_valid));
      check("mem_read",      32'(O_MEM_READ), 32'(exp_read));
      if (O_PC_ENABLE && prev_pulse) check("pc_enable_back_to_back", 32'd1, 32'd0);
      if (O_MEM_READ) check("mem_address_is_pc", 32'(O_MEM_ADDRESS), 32'(pc));
      if (O_INSTR_VALID) begin
        check("instr_data", 32'(O_INSTR), 32'(memf(O_INSTR_ADDRESS)));
        check("instr_address_is_pc", 32'(O_INSTR_ADDRESS), 32'(pc));
      end
      // PC environment reacts to this cycle's pulse before the next sample.
      if (exp_pulse) pc = exp_sel ? exp_pc_addr + {15'd0, exp_inc} : pc + 16'd1;
      prev_pulse = O_PC_ENABLE;
      // Predict next cycle.
      m_capture = prev_read_ok;
      m_busy    = O_MEM_READ || m_capture || O_INSTR_VALID;
      m_honored = m_busy && I_BRANCH_VALID;
      exp_pulse = m_honored || (O_INSTR_VALID && I_INSTR_READY);
      exp_sel   = m_honored;
      exp_inc   = m_honored && I_BRANCH_PLUS_ONE;
      if (m_honored) exp_pc_addr = I_BRANCH_TARGET;
      exp_valid = !m_honored && (m_capture || (O_INSTR_VALID && !I_INSTR_READY));
      exp_read  = !m_busy && I_ENABLE;
      prev_read_ok = O_MEM_READ && !I_BRANCH_VALID;
    end
  end

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic wait_for_read(input string name);
    int n = 0;
    do begin tick(); n++; end while (!O_MEM_READ && n < 20);
    check(name, 32'(O_MEM_READ), 32'd1);
  endtask

  task automatic wait_for_valid(input string name);
    int n = 0;
    do begin tick(); n++; end while (!O_INSTR_VALID && n < 20);
    check(name, 32'(O_INSTR_VALID), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge I_CLK);
    #1 I_NRESET = 1'b1;

    // Basic fetch from PC 0x0010 with decode always ready.
    tick();
    I_ENABLE = 1'b1; I_INSTR_READY = 1'b1;
    repeat (3) tick();
    check("basic_valid_latency", 32'(O_INSTR_VALID), 32'd1);
    check("basic_instr", 32'(O_INSTR), 32'h0000A5C3);
    check("basic_instr_addr", 32'(O_INSTR_ADDRESS), 32'h00000010);
    tick();
    check("basic_pulse", 32'(O_PC_ENABLE), 32'd1);
    check("basic_selects", 32'({O_PC_ADDRESS_SELECT, O_PC_ADDRESS_SELECT_INCREMENT}), 32'd0);
    I_INSTR_READY = 1'b0;

    // Backpressure: instruction held while decode stalls.
    repeat (3) tick();
    check("bp_instr_addr", 32'(O_INSTR_ADDRESS), 32'h00000011);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_held", 32'(O_INSTR_VALID), 32'd1);
      check("bp_no_pulse", 32'(O_PC_ENABLE), 32'd0);
    end
    I_INSTR_READY = 1'b1;
    tick();
    check("bp_accept_pulse", 32'(O_PC_ENABLE), 32'd1);
    I_INSTR_READY = 1'b0;
    tick();
    check("bp_single_pulse", 32'(O_PC_ENABLE), 32'd0);

    // Branch during capture to 0x0200 with plus-one.
    tick();
    I_BRANCH_VALID = 1'b1; I_BRANCH_TARGET = 16'h0200; I_BRANCH_PLUS_ONE = 1'b1;
    tick();
    I_BRANCH_VALID = 1'b0; I_BRANCH_PLUS_ONE = 1'b0;
    check("brc_pulse", 32'(O_PC_ENABLE), 32'd1);
    check("brc_select", 32'(O_PC_ADDRESS_SELECT), 32'd1);
    check("brc_select_inc", 32'(O_PC_ADDRESS_SELECT_INCREMENT), 32'd1);
    check("brc_pc_address", 32'(O_PC_ADDRESS), 32'h00000200);
    check("brc_no_valid", 32'(O_INSTR_VALID), 32'd0);
    wait_for_read("brc_next_read_seen");
    check("brc_next_fetch_addr", 32'(O_MEM_ADDRESS), 32'h00000201);

    // Branch together with ready while holding.
    tick();
    tick();
    check("brh_holding", 32'(O_INSTR_VALID), 32'd1);
    I_BRANCH_VALID = 1'b1; I_BRANCH_TARGET = 16'h0040; I_INSTR_READY = 1'b1;
    tick();
    I_BRANCH_VALID = 1'b0; I_INSTR_READY = 1'b0;
    check("brh_pulse", 32'(O_PC_ENABLE), 32'd1);
    check("brh_select", 32'(O_PC_ADDRESS_SELECT), 32'd1);
    check("brh_select_inc", 32'(O_PC_ADDRESS_SELECT_INCREMENT), 32'd0);
    tick();
    check("brh_single_pulse", 32'(O_PC_ENABLE), 32'd0);
    wait_for_valid("brh_next_valid_seen");
    check("brh_next_instr_addr", 32'(O_INSTR_ADDRESS), 32'h00000040);

    // Enable drop while holding: accept completes, then no more reads.
    I_ENABLE = 1'b0;
    repeat (2) tick();
    check("en_drop_still_valid", 32'(O_INSTR_VALID), 32'd1);
    I_INSTR_READY = 1'b1;
    tick();
    I_INSTR_READY = 1'b0;
    check("en_drop_accept_pulse", 32'(O_PC_ENABLE), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("en_drop_no_read", 32'(O_MEM_READ), 32'd0);
    end
    I_ENABLE = 1'b1;
    wait_for_read("en_resume_read_seen");

    // Asynchronous reset in the middle of a hold.
    wait_for_valid("rst_hold_seen");
    #1 I_NRESET = 1'b0;
    #1 check("rst_async_clear", 32'(any_out), 32'd0);
    tick();
    I_NRESET = 1'b1;
    wait_for_read("rst_restart_read_seen");

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      I_NRESET          = ($urandom_range(0, 399) != 0);
      I_ENABLE          = ($urandom_range(0, 7) != 0);
      I_INSTR_READY     = $urandom_range(0, 1) == 1;
      I_BRANCH_VALID    = ($urandom_range(0, 5) == 0);
      I_BRANCH_TARGET   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      I_BRANCH_PLUS_ONE = $urandom_range(0, 1) == 1;
    end
    tick();
    I_NRESET = 1'b1; I_BRANCH_VALID = 1'b0; I_INSTR_READY = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the CR16 program counter.
- Reads the PC value, issues a read to synchronous instruction memory, and holds the returned instruction in a register.
- Presents the instruction to decode with a valid/ready handshake.
- Generates the single-cycle enable/select controls that advance or redirect the PC after each accepted instruction or branch.

Parameters:
- P_ADDRESS_WIDTH, 16, width of PC and memory addresses.
- P_DATA_WIDTH, 16, width of an instruction word.

Ports:
- I_CLK  in  1  system clock; all state updates on rising edge.
- I_NRESET  in  1  asynchronous, active-low reset.
- I_ENABLE  in  1  run enable; a new fetch starts only while high.
- I_PC_ADDRESS  in  P_ADDRESS_WIDTH  current PC output value.
- O_PC_ENABLE  out  1  registered one-cycle pulse; the PC updates on its rising edge.
- O_PC_ADDRESS_SELECT  out  1  high together with the pulse for a branch redirect.
- O_PC_ADDRESS_SELECT_INCREMENT  out  1  high together with the pulse when the PC must load target+1.
- O_PC_ADDRESS  out  P_ADDRESS_WIDTH  redirect target driven to the PC.
- I_BRANCH_VALID  in  1  one-cycle branch request from execute.
- I_BRANCH_TARGET  in  P_ADDRESS_WIDTH  branch target.
- I_BRANCH_PLUS_ONE  in  1  request target+1 instead of target.
- O_MEM_READ  out  1  memory read strobe.
- O_MEM_ADDRESS  out  P_ADDRESS_WIDTH  memory read address.
- I_MEM_DATA  in  P_DATA_WIDTH  read data, valid exactly one cycle after O_MEM_READ.
- O_INSTR  out  P_DATA_WIDTH  captured instruction.
- O_INSTR_ADDRESS  out  P_ADDRESS_WIDTH  address the instruction was fetched from.
- O_INSTR_VALID  out  1  instruction available to decode.
- I_INSTR_READY  in  1  decode accepts the instruction.

Behaviour:
- Clock and reset: one clock (I_CLK). Reset I_NRESET is asynchronous and active-low.
- Reset: all outputs 0, state S_IDLE. Reset asserted mid-operation clears immediately; in-flight data is discarded.
- All outputs are registered except O_MEM_READ and O_MEM_ADDRESS, which are decoded from state and addr_q.
- FSM states and transitions:
  - S_IDLE: if I_ENABLE, latch addr_q <= I_PC_ADDRESS and go to S_READ.
  - S_READ: O_MEM_READ=1, O_MEM_ADDRESS=addr_q; go to S_CAPTURE.
  - S_CAPTURE: O_INSTR <= I_MEM_DATA, O_INSTR_ADDRESS <= addr_q, O_INSTR_VALID <= 1; go to S_HOLD.
  - S_HOLD: O_INSTR_VALID=1, O_INSTR stable. On I_INSTR_READY: O_INSTR_VALID <= 0, O_PC_ENABLE <= 1 with both selects 0 (PC increments); go to S_ADVANCE.
  - S_ADVANCE: O_PC_ENABLE <= 0. If I_ENABLE, latch addr_q <= I_PC_ADDRESS and go to S_READ; otherwise go to S_IDLE.
- Timing:
  - Latency: I_ENABLE sampled high in S_IDLE at edge N gives O_INSTR_VALID=1 after edge N+2.
  - Throughput: one instruction per 4 cycles when decode is always ready.
- Branch (I_BRANCH_VALID=1 in S_READ, S_CAPTURE or S_HOLD):
  - Cancels the fetch; memory data is ignored and O_INSTR_VALID <= 0.
  - O_PC_ADDRESS <= I_BRANCH_TARGET, O_PC_ADDRESS_SELECT <= 1, O_PC_ADDRESS_SELECT_INCREMENT <= I_BRANCH_PLUS_ONE, O_PC_ENABLE <= 1; go to S_ADVANCE.
  - Selects are cleared in S_ADVANCE with the pulse, so they are stable at the pulse's rising edge.
- Boundary conditions:
  - Branch and I_INSTR_READY in the same cycle: the branch wins, and the handshake counts as the accept of the held instruction. Only one PC pulse is issued.
  - Branch in S_IDLE or S_ADVANCE: ignored.
  - I_ENABLE low in S_HOLD: the instruction stays presented; the accept completes normally, then the FSM goes to S_IDLE.
  - I_INSTR_READY while O_INSTR_VALID=0: no effect.
  - Address wrap: PC value all-ones is fetched normally; wrap-around is the PC's responsibility.
  - O_PC_ENABLE is never high for two consecutive cycles.

Decomposition:
- Package cr16_fetch_pkg:
  - state enum fetch_state_t {S_IDLE, S_READ, S_CAPTURE, S_HOLD, S_ADVANCE}.
  - Default width constants.
- No sub-module: a single FSM plus registers.

Test Plan:
- Reset: assert I_NRESET=0 mid-S_HOLD -> all outputs 0 within the same cycle; after release, state is S_IDLE.
- Basic fetch: PC=0x0010, mem[0x0010]=0xA5C3, ready held 1 -> O_INSTR=0xA5C3, O_INSTR_ADDRESS=0x0010 valid 2 cycles after the enable sample; one O_PC_ENABLE pulse with selects 0.
- Backpressure: ready=0 for 5 cycles -> O_INSTR_VALID stays 1 and O_INSTR stable, no PC pulse; ready=1 -> exactly one pulse.
- Branch in S_CAPTURE: target 0x0200, plus_one=1 -> no valid asserted; pulse with select=1, increment=1, O_PC_ADDRESS=0x0200; next fetch uses PC=0x0201.
- Branch and ready together in S_HOLD: target 0x0040 -> a single pulse with select=1; next O_INSTR_ADDRESS=0x0040.
- Enable drop: I_ENABLE=0 during S_HOLD -> accept completes, FSM returns to S_IDLE, no further O_MEM_READ until I_ENABLE=1.
